harvard_mem_arbiter: RTL and testbench
======================================

// Module: harvard_mem_arbiter
// PURPOSE
//   Sequences a frozen-clock Harvard MIPS core (mips_cpu_harvard) onto one single-ported memory bus.
//   Per CPU step: fetch the instruction, let the core decode it, then perform at most one data access.
//   Then pulse clk_enable for one cycle so the core retires exactly one instruction.
//   Sits between mips_cpu_harvard and the shared RAM/ROM bus.
// PARAMETERS
//   ADDR_W   32   address width, CPU and memory side
//   DATA_W   32   data width, CPU and memory side
//   MAX_WAIT 255  max cycles one access may stall on mem_waitrequest before the watchdog aborts it
// PORTS
//   clk             in   1       single clock; all state updates on rising edge
//   reset_n         in   1       asynchronous, active-low reset
//   cpu_active      in   1       core's active output; low = core halted
//   clk_enable      out  1       core step strobe; high for exactly one cycle per retired instruction
//   instr_address   in   ADDR_W  core fetch address (stable while clk_enable low)
//   instr_readdata  out  DATA_W  registered fetched instruction
//   data_address    in   ADDR_W  core data address
//   data_read       in   1       core data read request (combinational from instr_readdata)
//   data_write      in   1       core data write request
//   data_writedata  in   DATA_W  core store data
//   data_readdata   out  DATA_W  registered load data
//   mem_address     out  ADDR_W  shared bus address
//   mem_read        out  1       shared bus read strobe
//   mem_write       out  1       shared bus write strobe
//   mem_writedata   out  DATA_W  shared bus write data
//   mem_readdata    in   DATA_W  valid in any cycle where (mem_read & !mem_waitrequest)
//   mem_waitrequest in   1       memory stall; an access completes on an edge where it is low
//   halted          out  1       high in HALT state
//   bus_err         out  1       sticky; set by watchdog abort or by data_read & data_write together
// BEHAVIOUR
//   Reset (async, reset_n=0): state=FETCH, clk_enable=0, mem_read=0, mem_write=0, halted=0, bus_err=0.
//     Also clears instr_readdata, data_readdata, mem_address, mem_writedata and the wait counter.
//   FETCH: mem_address=instr_address, mem_read=1.
//     On an edge with !mem_waitrequest: instr_readdata<=mem_readdata, go to DECIDE.
//   DECIDE: one settle cycle with no bus strobe, so the core decodes the new instr_readdata.
//     If cpu_active=0, go to HALT.
//     Else if data_write, go to DATA_WR; if both data_read and data_write, also set bus_err (write wins).
//     Else if data_read, go to DATA_RD.
//     Else go to RELEASE.
//   DATA_RD: mem_address=data_address, mem_read=1.
//     On !mem_waitrequest: data_readdata<=mem_readdata, go to RELEASE.
//   DATA_WR: mem_address=data_address, mem_write=1, mem_writedata=data_writedata.
//     On !mem_waitrequest, go to RELEASE.
//   RELEASE: clk_enable=1 for this cycle only, then FETCH. clk_enable is 0 in every other state.
//   HALT: all strobes 0, halted=1. Leaves only on reset_n=0.
//   Bus strobes are registered and never glitch. mem_read and mem_write are never high together.
//   An address and its strobe stay held constant until the completing edge.
//   Watchdog: counter clears on entering FETCH, DATA_RD or DATA_WR, and increments each stalled cycle.
//     On reaching MAX_WAIT: abort the access, set bus_err, load 0 into the target buffer, go to the next state.
//   Latency, zero-wait memory: 3 cycles per instruction without a data access, 4 with one.
//   Reset mid-access: strobes drop asynchronously; no partial write is retried.
//   DATA_RD never re-fetches. instr_readdata holds through DATA_* and RELEASE.
// STRUCTURE
//   harvard_mem_arbiter_pkg: arb_state_t enum {FETCH,DECIDE,DATA_RD,DATA_WR,RELEASE,HALT}.
//     Same package: default ADDR_W, DATA_W and MAX_WAIT constants.
//   Sub-module harvard_mem_arbiter_watchdog: wait counter with clear, tick and expired.
//     Width is $clog2(MAX_WAIT+1).
//   Top: FSM, output muxes and the readdata buffer registers.
// TESTING
//   T1 reset: drive reset_n=0 mid-DATA_WR with mem_write=1.
//     -> mem_write=0 immediately (async), state FETCH, bus_err=0.
//   T2 ALU op, zero wait: fetch 0x24010020 at 0xBFC00000.
//     -> mem_read high for 1 cycle, clk_enable pulses on cycle 3, no data strobe.
//   T3 load, 2-cycle wait: lw at 0xBFC00004, data_address=0x10, mem_readdata=0xF0000000.
//     -> data_readdata=0xF0000000, clk_enable on cycle 6.
//   T4 store: data_write=1, data_address=0x20, data_writedata=0xDEADBEEF.
//     -> exactly one mem_write cycle with those values, mem_read=0 during it.
//   T5 watchdog: hold mem_waitrequest=1 in FETCH with MAX_WAIT=4.
//     -> bus_err=1 after 4 stalled cycles, instr_readdata=0, FSM advances.
//   T6 halt: cpu_active=0 sampled in DECIDE.
//     -> halted=1, no further clk_enable or strobes for 20 cycles.

Source files
------------

// File: rtl/harvard_mem_arbiter_pkg.sv
// Shared types and default sizing for the Harvard-core memory arbiter.
// States follow one CPU step: fetch, decode settle, optional data access, retire.
package harvard_mem_arbiter_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 255;

    typedef enum logic [2:0] {
        FETCH,
        DECIDE,
        DATA_RD,
        DATA_WR,
        RELEASE,
        HALT
    } arb_state_t;

    function automatic logic is_access(arb_state_t s);
        return (s == FETCH) || (s == DATA_RD) || (s == DATA_WR);
    endfunction

endpackage

// File: rtl/harvard_mem_arbiter_if.sv
// Shared single-ported memory bus: arbiter is master, RAM/ROM is slave.
// An access completes on a rising edge where mem_waitrequest is low.
interface harvard_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_waitrequest
    );
endinterface

// File: rtl/harvard_mem_arbiter_watchdog.sv
// Per-access stall counter; expired_o fires on the stalled cycle that
// brings the count to MAX_WAIT so the caller can abort on that edge.
module harvard_mem_arbiter_watchdog
    import harvard_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = tick_i && (cnt_q == CNT_W'(MAX_WAIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (tick_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/harvard_mem_arbiter.sv
// Steps a frozen-clock Harvard MIPS core over one shared memory bus:
// fetch, decode settle, at most one data access, then one clk_enable pulse.
module harvard_mem_arbiter
    import harvard_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_active,
    output logic              clk_enable,
    input  logic [ADDR_W-1:0] instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    input  logic [ADDR_W-1:0] data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [DATA_W-1:0] data_writedata,
    output logic [DATA_W-1:0] data_readdata,
    output logic              halted,
    output logic              bus_err,
    harvard_mem_arbiter_if.master bus
);
    arb_state_t state_q, state_d;

    logic              rd_q, wr_q, clk_en_q, halted_q, err_q;
    logic [DATA_W-1:0] ir_q, dr_q, rd_val;
    logic              set_err, ir_ld, dr_ld;
    logic              done, tick, wd_exp, wd_clr;

    assign done   = (rd_q | wr_q) & ~bus.mem_waitrequest;
    assign tick   = (rd_q | wr_q) &  bus.mem_waitrequest;
    assign rd_val = done ? bus.mem_readdata : '0;
    assign wd_clr = is_access(state_d) && (state_d != state_q);

    harvard_mem_arbiter_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wd (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (wd_clr),
        .tick_i    (tick),
        .expired_o (wd_exp)
    );

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        ir_ld   = 1'b0;
        dr_ld   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (done || wd_exp) begin
                    state_d = DECIDE;
                    ir_ld   = 1'b1;
                    set_err = wd_exp;
                end
            end
            DECIDE: begin
                if (!cpu_active)
                    state_d = HALT;
                else if (data_write) begin
                    state_d = DATA_WR;
                    set_err = data_read;
                end else if (data_read)
                    state_d = DATA_RD;
                else
                    state_d = RELEASE;
            end
            DATA_RD: begin
                if (done || wd_exp) begin
                    state_d = RELEASE;
                    dr_ld   = 1'b1;
                    set_err = wd_exp;
                end
            end
            DATA_WR: begin
                if (done || wd_exp) begin
                    state_d = RELEASE;
                    set_err = wd_exp;
                end
            end
            RELEASE: state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Strobes are flops fed from the next state, so they never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            clk_en_q <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            ir_q     <= '0;
            dr_q     <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= (state_d == FETCH) || (state_d == DATA_RD);
            wr_q     <= (state_d == DATA_WR);
            clk_en_q <= (state_d == RELEASE);
            halted_q <= (state_d == HALT);
            err_q    <= err_q | set_err;
            if (ir_ld)
                ir_q <= rd_val;
            if (dr_ld)
                dr_q <= rd_val;
        end
    end

    // PC moves on the retiring edge, so the fetch address is steered live.
    assign bus.mem_address   = (rd_q && state_q == FETCH) ? instr_address :
                               (rd_q | wr_q)             ? data_address  : '0;
    assign bus.mem_read      = rd_q;
    assign bus.mem_write     = wr_q;
    assign bus.mem_writedata = wr_q ? data_writedata : '0;

    assign clk_enable     = clk_en_q;
    assign halted         = halted_q;
    assign bus_err        = err_q;
    assign instr_readdata = ir_q;
    assign data_readdata  = dr_q;
endmodule

// File: tb/tb_harvard_mem_arbiter.sv
// Scoreboard bench: steps push expected retire/write records, a negedge
// monitor pops them when clk_enable or a completing write appears.
module tb_harvard_mem_arbiter;
    import harvard_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    localparam logic [31:0] MADDR [7] = '{
        32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
        32'hBFC00010, 32'hBFC00018, 32'h00000010
    };
    localparam logic [31:0] MDATA [7] = '{
        32'h24010020, 32'h8C010010, 32'hAC010020, 32'hAC010030,
        32'h3C01ABCD, 32'h0000000C, 32'hF0000000
    };

    typedef struct {
        logic [31:0] ir;
        logic [31:0] dr;
        logic        err;
        int          cyc;
        int          rd;
        int          wr;
    } step_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_active;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        halted;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int fetch_wait = 0;
    int data_wait = 0;
    int elapsed;
    int cur_wait;
    logic [31:0] rdata;

    step_t step_q[$];
    wr_t   wr_q[$];

    always #5 clk = ~clk;

    harvard_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    harvard_mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_active     (cpu_active),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .halted         (halted),
        .bus_err        (bus_err),
        .bus            (bus)
    );

    // Memory model: ROM region 0xB... uses fetch_wait, everything else data_wait.
    always_comb begin
        cur_wait = (bus.mem_address[31:28] == 4'hB) ? fetch_wait : data_wait;
        rdata = 32'h0;
        for (int i = 0; i < 7; i++)
            if (bus.mem_read && bus.mem_address == MADDR[i])
                rdata = MDATA[i];
    end

    assign bus.mem_readdata    = rdata;
    assign bus.mem_waitrequest = (bus.mem_read | bus.mem_write) && (elapsed < cur_wait);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            elapsed <= 0;
        else if (bus.mem_waitrequest)
            elapsed <= elapsed + 1;
        else
            elapsed <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor
    int  m_cyc = 0;
    int  m_rd = 0;
    int  m_wr = 0;
    bit  m_on = 0;

    always @(negedge clk) begin
        step_t s;
        wr_t   w;
        if (!reset_n) begin
            m_on = 0; m_cyc = 0; m_rd = 0; m_wr = 0;
        end else begin
            if (!m_on && bus.mem_read)
                m_on = 1;
            if (m_on) begin
                m_cyc++;
                m_rd += int'(bus.mem_read);
                m_wr += int'(bus.mem_write);
            end
            if (bus.mem_write && !bus.mem_waitrequest) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", bus.mem_address, w.addr);
                    chk("wr_data", bus.mem_writedata, w.data);
                    chk("wr_no_read", {31'b0, bus.mem_read}, 32'd0);
                end
            end
            if (clk_enable) begin
                if (step_q.size() == 0) begin
                    chk("unexpected_clk_enable", 32'd1, 32'd0);
                end else begin
                    s = step_q.pop_front();
                    chk("instr_readdata", instr_readdata, s.ir);
                    chk("data_readdata", data_readdata, s.dr);
                    chk("bus_err", {31'b0, bus_err}, {31'b0, s.err});
                    chk("step_cycles", m_cyc, s.cyc);
                    chk("read_cycles", m_rd, s.rd);
                    chk("write_cycles", m_wr, s.wr);
                end
                m_on = 0; m_cyc = 0; m_rd = 0; m_wr = 0;
            end
        end
    end

    task automatic set_cpu(input logic [31:0] ia, input logic dr, input logic dw,
                           input logic [31:0] da, input logic [31:0] wd, input logic act);
        instr_address  = ia;
        data_read      = dr;
        data_write     = dw;
        data_address   = da;
        data_writedata = wd;
        cpu_active     = act;
    endtask

    task automatic push_step(input logic [31:0] ir, input logic [31:0] dr, input logic err,
                             input int cyc, input int rd, input int wr);
        step_t s;
        s.ir = ir; s.dr = dr; s.err = err; s.cyc = cyc; s.rd = rd; s.wr = wr;
        step_q.push_back(s);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic wait_retire();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (clk_enable)
                break;
        end
        chk("retire_in_time", {31'b0, n < 200}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int strobes;
        set_cpu(32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #12;
        chk("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
        chk("rst_clk_enable", {31'b0, clk_enable}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_instr_rd", instr_readdata, 32'h0);
        chk("rst_data_rd", data_readdata, 32'h0);
        chk("rst_mem_addr", bus.mem_address, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU op, zero wait
        push_step(32'h24010020, 32'h0, 1'b0, 3, 1, 0);
        wait_retire();

        // Load, two wait states on the data access
        set_cpu(32'hBFC00004, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        data_wait = 2;
        push_step(32'h8C010010, 32'hF0000000, 1'b0, 6, 4, 0);
        wait_retire();

        // Store
        set_cpu(32'hBFC00008, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b1);
        data_wait = 0;
        push_wr(32'h20, 32'hDEADBEEF);
        push_step(32'hAC010020, 32'hF0000000, 1'b0, 4, 1, 1);
        wait_retire();

        // Read and write together: write wins, bus_err set
        set_cpu(32'hBFC0000C, 1'b1, 1'b1, 32'h30, 32'h12345678, 1'b1);
        push_wr(32'h30, 32'h12345678);
        push_step(32'hAC010030, 32'hF0000000, 1'b1, 4, 1, 1);
        wait_retire();

        // Watchdog abort on a stuck fetch
        set_cpu(32'hBFC00010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        fetch_wait = 100;
        push_step(32'h0, 32'hF0000000, 1'b1, 6, 4, 0);
        wait_retire();
        fetch_wait = 0;

        // Reset during a stalled store
        set_cpu(32'hBFC00014, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b1);
        data_wait = 100;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.mem_write)
                break;
        end
        chk("t1_reach_write", {31'b0, n < 50}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_mem_write_async", {31'b0, bus.mem_write}, 32'd0);
        chk("t1_mem_read", {31'b0, bus.mem_read}, 32'd0);
        chk("t1_bus_err", {31'b0, bus_err}, 32'd0);
        chk("t1_clk_enable", {31'b0, clk_enable}, 32'd0);
        data_wait = 0;
        set_cpu(32'hBFC00018, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Halt
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (halted)
                break;
        end
        chk("t6_halted", {31'b0, halted}, 32'd1);
        chk("t6_instr", instr_readdata, 32'h0000000C);
        strobes = 0;
        repeat (20) begin
            @(negedge clk);
            strobes += int'(bus.mem_read) + int'(bus.mem_write) + int'(clk_enable);
        end
        chk("t6_quiet", strobes, 0);
        chk("t6_still_halted", {31'b0, halted}, 32'd1);

        chk("steps_left", step_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
